pipelined_adder: RTL and testbench

- Parametrised, pipelined ripple-carry adder with valid/ready handshakes on input and output.
- Splits a WIDTH-bit add of A + B + Cin into STAGES equal chunks, adding one chunk per pipeline stage and registering the carry between stages.
- Sustains one result per cycle at full clock rate.
- Next-generation replacement for the combinational 4-bit full adder; sits between operand producers and consumers that may apply backpressure.

---
 rtl/pipelined_adder_pkg.sv | 11 +
 rtl/pipelined_adder_stage.sv | 109 ++++++++++
 rtl/pipelined_adder.sv | 110 +++++++++++
 tb/tb_pipelined_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and sizing helper for the pipelined ripple-carry adder.
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? 0 : width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: adds chunk IDX of the operands and registers the partial result.
// Sign-bit tracking and overflow flag exist only when PIPE_ADDER_OVF_EN is defined.
module pipelined_adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES,
  parameter int unsigned IDX    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             carry_i,
`ifdef PIPE_ADDER_OVF_EN
  input  logic [1:0]       sign_i,
  output logic [1:0]       sign_o,
  output logic             ovf_o,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned CHUNK = chunk_w(WIDTH, STAGES);
  localparam int unsigned LO    = IDX * CHUNK;
  localparam int unsigned HI    = LO + CHUNK;

  logic             valid_q;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] upper_mask;
  logic [CHUNK:0]   chunk_sum;

  // Only operand bits above this chunk travel on; lower ones are already summed.
  always_comb begin
    upper_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      upper_mask[i] = (i >= HI);
    end
  end

  always_comb begin
    chunk_sum = {1'b0, a_i[LO +: CHUNK]} + {1'b0, b_i[LO +: CHUNK]} + {{CHUNK{1'b0}}, carry_i};
    sum_d     = sum_i;
    sum_d[LO +: CHUNK] = chunk_sum[CHUNK-1:0];
    carry_d   = chunk_sum[CHUNK];
    a_d       = a_i & upper_mask;
    b_d       = b_i & upper_mask;
  end

  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        a_q     <= a_d;
        b_q     <= b_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

`ifdef PIPE_ADDER_OVF_EN
  logic [1:0] sign_q;
  logic       ovf_q, ovf_d;

  // Meaningful only in the last stage, where sum_d holds the final MSB.
  always_comb begin
    ovf_d = (sign_i[1] == sign_i[0]) && (sum_d[WIDTH-1] != sign_i[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= '0;
      ovf_q  <= 1'b0;
    end else if (ready_o && valid_i) begin
      sign_q <= sign_i;
      ovf_q  <= ovf_d;
    end
  end

  assign sign_o = sign_q;
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, WIDTH bits split over STAGES chunk stages, valid/ready both ends.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  if (WIDTH < 1) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be >= 1");
  end else if (WIDTH % STAGES != 0) begin : g_bad_split
    $error("pipelined_adder: STAGES must divide WIDTH");
  end

  logic [STAGES:0]            valid_w;
  logic [STAGES:0]            carry_w;
  logic [STAGES:0][WIDTH-1:0] a_w;
  logic [STAGES:0][WIDTH-1:0] b_w;
  logic [STAGES:0][WIDTH-1:0] sum_w;
  logic [STAGES-1:0]          ready_w;
  logic [STAGES-1:0]          down_ready;
`ifdef PIPE_ADDER_OVF_EN
  logic [STAGES:0][1:0]       sign_w;
  logic [STAGES-1:0]          ovf_w;
`endif

  assign valid_w[0] = in_valid;
  assign a_w[0]     = a;
  assign b_w[0]     = b;
  assign sum_w[0]   = '0;
  assign carry_w[0] = cin;
`ifdef PIPE_ADDER_OVF_EN
  assign sign_w[0]  = {a[WIDTH-1], b[WIDTH-1]};
`endif

  // Downstream ready unrolled from the registered valids (equivalent to chaining
  // ready_{k+1}) so no combinational vector feeds back into itself.
  always_comb begin
    down_ready = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      down_ready[k] = out_ready;
      for (int unsigned j = k + 2; j <= STAGES; j++) begin
        if (!valid_w[j]) down_ready[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_adder_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (valid_w[k]),
      .ready_o (ready_w[k]),
      .a_i     (a_w[k]),
      .b_i     (b_w[k]),
      .sum_i   (sum_w[k]),
      .carry_i (carry_w[k]),
`ifdef PIPE_ADDER_OVF_EN
      .sign_i  (sign_w[k]),
      .sign_o  (sign_w[k+1]),
      .ovf_o   (ovf_w[k]),
`endif
      .valid_o (valid_w[k+1]),
      .ready_i (down_ready[k]),
      .a_o     (a_w[k+1]),
      .b_o     (b_w[k+1]),
      .sum_o   (sum_w[k+1]),
      .carry_o (carry_w[k+1])
    );
  end

  assign in_ready  = ready_w[0];
  assign out_valid = valid_w[STAGES];
  assign sum       = sum_w[STAGES];
  assign cout      = carry_w[STAGES];

`ifdef PIPE_ADDER_OVF_EN
  assign ovf = ovf_w[STAGES-1];

  logic unused_tail;
  assign unused_tail = ^{a_w[STAGES], b_w[STAGES], ready_w, sign_w[STAGES], ovf_w};
`else
  logic unused_tail;
  assign unused_tail = ^{a_w[STAGES], b_w[STAGES], ready_w};
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4); ovf checked when PIPE_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

  localparam int unsigned W     = 32;
  localparam int unsigned S     = 4;
  localparam int unsigned NRAND = 200;
`ifdef PIPE_ADDER_OVF_EN
  localparam logic [W+1:0] CMP_MASK = '1;
`else
  localparam logic [W+1:0] CMP_MASK = {1'b0, {(W+1){1'b1}}};
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
  logic         ovf_s;

  int           errors = 0;
  int           checks = 0;
  int unsigned  cyc = 0;
  int unsigned  pops = 0;
  int unsigned  last_pop_cyc = 0;
  int unsigned  acc_cyc = 0;
  logic         stall_en = 1'b0;
  logic [W+1:0] exp_q[$];

  logic [W-1:0] ra[NRAND];
  logic [W-1:0] rb[NRAND];
  logic         rc[NRAND];

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef PIPE_ADDER_OVF_EN
    .ovf       (ovf_s),
`endif
    .cout      (cout)
  );

`ifndef PIPE_ADDER_OVF_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stall_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (r[W-1] != x[W-1]), r};
  endfunction

  // Monitor: all samples taken 1 time unit before the rising edge.
  initial begin : monitor
    logic         held;
    logic [W+1:0] held_val, act;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      act = {ovf_s, cout, sum};
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", {{(W+1){1'b0}}, out_valid}, 1);
          check("hold_data", act, held_val);
        end
        if (out_valid && out_ready) begin
          pops++;
          last_pop_cyc = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected no output", act);
          end else begin
            check("result", act & CMP_MASK, exp_q.pop_front() & CMP_MASK);
          end
          held = 1'b0;
        end else if (out_valid) begin
          held     = 1'b1;
          held_val = act;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W+1:0] e);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    cin = tc;
    for (int unsigned n = 0; n < 1000 && !done; n++) begin
      if (n > 0) @(negedge clk);
      #4;
      if (in_ready) begin
        exp_q.push_back(e);
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    @(posedge clk);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 1000 cycles expected acceptance");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain", W'(exp_q.size()), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [W-1:0] da[8];
    logic [W-1:0] db[8];
    logic         dc[8];
    logic [W+1:0] de[8];
    int unsigned  first_acc, p0, k;

    // {ovf, cout, sum}, computed by hand
    da[0] = 32'hFFFF_FFFF; db[0] = 32'h0000_0000; dc[0] = 1'b1; de[0] = {1'b0, 1'b1, 32'h0000_0000};
    da[1] = 32'h7FFF_FFFF; db[1] = 32'h0000_0001; dc[1] = 1'b0; de[1] = {1'b1, 1'b0, 32'h8000_0000};
    da[2] = 32'hFFFF_FFFF; db[2] = 32'h0000_0001; dc[2] = 1'b0; de[2] = {1'b0, 1'b1, 32'h0000_0000};
    da[3] = 32'h1234_5678; db[3] = 32'h8765_4321; dc[3] = 1'b0; de[3] = {1'b0, 1'b0, 32'h9999_9999};
    da[4] = 32'h8000_0000; db[4] = 32'h8000_0000; dc[4] = 1'b0; de[4] = {1'b1, 1'b1, 32'h0000_0000};
    da[5] = 32'h0000_FFFF; db[5] = 32'h0000_0001; dc[5] = 1'b1; de[5] = {1'b0, 1'b0, 32'h0001_0001};
    da[6] = 32'hFFFF_FFFF; db[6] = 32'hFFFF_FFFF; dc[6] = 1'b1; de[6] = {1'b0, 1'b1, 32'hFFFF_FFFF};
    da[7] = 32'h00FF_00FF; db[7] = 32'h0001_0001; dc[7] = 1'b0; de[7] = {1'b0, 1'b0, 32'h0100_0100};

    for (int i = 0; i < int'(NRAND); i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
      rc[i] = 1'($urandom_range(0, 1));
    end

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    #2;
    check("reset_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
    check("reset_sum", {2'b00, sum}, 0);
    check("reset_cout", {{(W+1){1'b0}}, cout}, 0);
    check("reset_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full carry ripple on an empty pipe, with latency measurement
    send(da[0], db[0], dc[0], de[0]);
    idle();
    drain();
    check("latency", W'(last_pop_cyc - acc_cyc), S);

    for (int i = 1; i < 8; i++) send(da[i], db[i], dc[i], de[i]);
    idle();
    drain();

    // Back-to-back streaming, no stalls
    for (int i = 0; i < int'(NRAND); i++) begin
      send(ra[i], rb[i], rc[i], model(ra[i], rb[i], rc[i]));
      if (i == 0) first_acc = acc_cyc;
    end
    idle();
    drain();
    check("stream_throughput", W'(last_pop_cyc - first_acc), NRAND - 1 + S);

    // Backpressure: fill, then one simultaneous retire/accept
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) out_ready = 1'b0;
      in_valid = 1'b1; a = ra[k]; b = rb[k]; cin = rc[k];
      #4;
      if (in_ready) begin
        exp_q.push_back(model(ra[k], rb[k], rc[k]));
        k++;
      end
    end
    check("bp_accepted", W'(k), S);
    check("bp_full_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
    p0 = pops;
    @(negedge clk);
    out_ready = 1'b1;
    #4;
    check("bp_release_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
    if (in_ready) begin
      exp_q.push_back(model(ra[k], rb[k], rc[k]));
      k++;
    end
    @(posedge clk);
    #1;
    check("bp_one_out", W'(pops - p0), 1);
    @(negedge clk);
    out_ready = 1'b0;
    a = ra[k]; b = rb[k]; cin = rc[k];
    #4;
    check("bp_refull_in_ready", {{(W+1){1'b0}}, in_ready}, 0);
    idle();
    out_ready = 1'b1;
    drain();

    // Same operand stream under random output stalls
    stall_en = 1'b1;
    for (int i = 0; i < int'(NRAND); i++) send(ra[i], rb[i], rc[i], model(ra[i], rb[i], rc[i]));
    idle();
    drain();
    stall_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset with three results in flight
    for (int i = 0; i < 3; i++) send(da[i + 3], db[i + 3], dc[i + 3], de[i + 3]);
    idle();
    repeat (3) @(negedge clk);
    check("pre_reset_out_valid", {{(W+1){1'b0}}, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
    check("midreset_sum", {2'b00, sum}, 0);
    check("midreset_cout", {{(W+1){1'b0}}, cout}, 0);
    check("midreset_in_ready", {{(W+1){1'b0}}, in_ready}, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    p0 = pops;
    repeat (8) @(negedge clk);
    check("post_reset_no_output", W'(pops - p0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
